vedic_mul_acc: RTL and testbench

- Accumulation stage placed directly downstream of the 32x32 Vedic multiplier.
- Consumes its 64-bit products over a valid/ready handshake and sums a group of products (a dot product) into a wide accumulator.
- The last product of a group is flagged; the block then presents the registered sum, product count and overflow flag on an output handshake.

---
 rtl/vedic_pkg.sv | 20 ++
 rtl/vedic_mul_acc_if.sv | 30 +++
 rtl/vedic_acc_add.sv | 34 +++
 rtl/vedic_mul_acc.sv | 113 +++++++++++
 tb/tb_vedic_mul_acc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier accumulation stage.
// Optional build macro used by this slice: VEDIC_ACC_SAT_EN (saturating accumulator).
package vedic_pkg;

  localparam int VEDIC_PROD_W = 64;
  localparam int VEDIC_ACC_W  = 72;
  localparam int VEDIC_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } vedic_acc_state_e;

  // The block takes products in every state except while a result is pending.
  function automatic logic vedic_accepts(input vedic_acc_state_e s);
    return (s != DONE);
  endfunction

endpackage

// File: rtl/vedic_mul_acc_if.sv
// Product-in / result-out handshake bundle for vedic_mul_acc.
// slave : the accumulator's view; master : the producer/consumer view.
interface vedic_mul_acc_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
);

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              prod_last;

  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_ovf;

  modport slave (
    input  prod_valid, prod, prod_last, acc_ready,
    output prod_ready, acc_valid, acc, acc_count, acc_ovf
  );

  modport master (
    output prod_valid, prod, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc, acc_count, acc_ovf
  );

endinterface

// File: rtl/vedic_acc_add.sv
// Unsigned accumulator adder: acc + zero-extended product, with carry out.
// With VEDIC_ACC_SAT_EN defined the sum clamps to all-ones on carry out;
// otherwise it wraps modulo 2^ACC_W.
module vedic_acc_add
  import vedic_pkg::*;
#(
  parameter int PROD_W = VEDIC_PROD_W,
  parameter int ACC_W  = VEDIC_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_sum_full;

  assign w_sum_full = {1'b0, i_acc} + (ACC_W+1)'(i_prod);

  // Select wrapped or clamped sum and expose the carry at bit ACC_W.
  always_comb begin
    o_carry = w_sum_full[ACC_W];
`ifdef VEDIC_ACC_SAT_EN
    if (w_sum_full[ACC_W]) begin
      o_sum = {ACC_W{1'b1}};
    end else begin
      o_sum = w_sum_full[ACC_W-1:0];
    end
`else
    o_sum = w_sum_full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/vedic_mul_acc.sv
// Accumulation stage behind the 32x32 Vedic multiplier: sums a group of
// products (flagged by prod_last) and presents sum, count and overflow.
// Optional build macro: VEDIC_ACC_SAT_EN (saturating accumulator, see vedic_acc_add).
module vedic_mul_acc
  import vedic_pkg::*;
#(
  parameter int PROD_W = VEDIC_PROD_W,
  parameter int ACC_W  = VEDIC_ACC_W,
  parameter int CNT_W  = VEDIC_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  vedic_mul_acc_if.slave  bus
);

  vedic_acc_state_e r_state;
  vedic_acc_state_e w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_acc_valid;

  logic             w_prod_ready;
  logic             w_xfer;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  // ready is a pure decode of the registered state, never of prod_valid
  assign w_prod_ready = vedic_accepts(r_state);
  assign w_xfer       = bus.prod_valid & w_prod_ready;

  vedic_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_prod  (bus.prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Next-state and next-datapath decode for the group FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_acc_nxt   = ACC_W'(bus.prod);
          w_cnt_nxt   = CNT_W'(1'b1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = bus.prod_last ? DONE : ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_xfer) begin
          w_acc_nxt = w_sum;
          if (r_cnt == {CNT_W{1'b1}}) begin
            w_cnt_nxt = r_cnt;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
          end
          w_ovf_nxt   = r_ovf | w_carry;
          w_state_nxt = bus.prod_last ? DONE : ACCUM;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      DONE: begin
        if (bus.acc_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and result registers; synchronous active-low reset drops any partial group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_acc_valid <= (w_state_nxt == DONE);
    end
  end

  assign bus.prod_ready = w_prod_ready;
  assign bus.acc_valid  = r_acc_valid;
  assign bus.acc        = r_acc;
  assign bus.acc_count  = r_cnt;
  assign bus.acc_ovf    = r_ovf;

endmodule

// File: tb/tb_vedic_mul_acc.sv
// Self-checking bench for vedic_mul_acc. Three instances share one stimulus:
// default widths, ACC_W=64 (overflow behaviour) and CNT_W=2 (count saturation).
module tb_vedic_mul_acc;

  logic        clk;
  logic        rst_n;
  logic        tb_prod_valid;
  logic [63:0] tb_prod;
  logic        tb_prod_last;
  logic        tb_acc_ready;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [71:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    int              n;
    logic [4:0][63:0] p;
    logic [71:0]     acc;
    logic [7:0]      cnt;
    logic            ovf;
    logic [63:0]     acc64;
    logic            ovf64;
    logic [1:0]      cnt2;
  } vec_t;
  vec_t vecs[7];

`ifdef VEDIC_ACC_SAT_EN
  localparam logic [63:0] W64_OVF2 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] W64_OVF4 = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] W64_OVF2 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] W64_OVF4 = 64'hFFFF_FFFF_FFFF_FFFC;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vedic_mul_acc_if #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) if_def ();
  vedic_mul_acc_if #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) if_w64 ();
  vedic_mul_acc_if #(.PROD_W(64), .ACC_W(72), .CNT_W(2)) if_c2 ();

  assign if_def.prod_valid = tb_prod_valid;
  assign if_def.prod       = tb_prod;
  assign if_def.prod_last  = tb_prod_last;
  assign if_def.acc_ready  = tb_acc_ready;
  assign if_w64.prod_valid = tb_prod_valid;
  assign if_w64.prod       = tb_prod;
  assign if_w64.prod_last  = tb_prod_last;
  assign if_w64.acc_ready  = tb_acc_ready;
  assign if_c2.prod_valid  = tb_prod_valid;
  assign if_c2.prod        = tb_prod;
  assign if_c2.prod_last   = tb_prod_last;
  assign if_c2.acc_ready   = tb_acc_ready;

  vedic_mul_acc #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
  vedic_mul_acc #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) u_w64 (.clk(clk), .rst_n(rst_n), .bus(if_w64));
  vedic_mul_acc #(.PROD_W(64), .ACC_W(72), .CNT_W(2)) u_c2  (.clk(clk), .rst_n(rst_n), .bus(if_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [63:0] p0, input logic [63:0] p1,
                              input logic [63:0] p2, input logic [63:0] p3, input logic [63:0] p4,
                              input logic [71:0] acc, input logic [7:0] cnt, input logic ovf,
                              input logic [63:0] acc64, input logic ovf64, input logic [1:0] cnt2);
    vec_t v;
    v.n = n;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3; v.p[4] = p4;
    v.acc = acc; v.cnt = cnt; v.ovf = ovf;
    v.acc64 = acc64; v.ovf64 = ovf64; v.cnt2 = cnt2;
    return v;
  endfunction

  // Scoreboard: pop on every result handshake of the default instance.
  always @(negedge clk) begin
    if (rst_n && if_def.acc_valid && tb_acc_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 72'd1, 72'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_acc", if_def.acc, e.acc);
        chk("sb_count", {64'd0, if_def.acc_count}, {64'd0, e.cnt});
        chk("sb_ovf", {71'd0, if_def.acc_ovf}, {71'd0, e.ovf});
      end
    end
  end

  // Offer one product and wait (bounded) until it transfers; returns at posedge+1.
  task automatic send(input logic [63:0] p, input logic l);
    bit done;
    done = 1'b0;
    tb_prod_valid = 1'b1;
    tb_prod       = p;
    tb_prod_last  = l;
    for (int k = 0; k < 20 && !done; k++) begin
      if (if_def.prod_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    chk("send_transfer", {71'd0, done}, 72'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    tb_prod_valid = 1'b0;
    tb_prod = 64'd0;
    tb_prod_last = 1'b0;
    tb_acc_ready = 1'b1;

    vecs[0] = mk(3, 64'd5, 64'd7, 64'd9, 64'd0, 64'd0, 72'd21, 8'd3, 1'b0, 64'd21, 1'b0, 2'd3);
    vecs[1] = mk(1, 64'h1234, 64'd0, 64'd0, 64'd0, 64'd0, 72'h1234, 8'd1, 1'b0, 64'h1234, 1'b0, 2'd1);
    vecs[2] = mk(2, ONES, 64'd2, 64'd0, 64'd0, 64'd0, 72'h01_0000_0000_0000_0001, 8'd2, 1'b0,
                 W64_OVF2, 1'b1, 2'd2);
    vecs[3] = mk(1, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0, 72'd4, 8'd1, 1'b0, 64'd4, 1'b0, 2'd1);
    vecs[4] = mk(4, ONES, ONES, ONES, ONES, 64'd0, 72'h03_FFFF_FFFF_FFFF_FFFC, 8'd4, 1'b0,
                 W64_OVF4, 1'b1, 2'd3);
    vecs[5] = mk(5, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 72'd5, 8'd5, 1'b0, 64'd5, 1'b0, 2'd3);
    vecs[6] = mk(2, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 72'd0, 8'd2, 1'b0, 64'd0, 1'b0, 2'd2);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_acc", if_def.acc, 72'd0);
    chk("rst_count", {64'd0, if_def.acc_count}, 72'd0);
    chk("rst_ovf", {71'd0, if_def.acc_ovf}, 72'd0);
    chk("rst_valid", {71'd0, if_def.acc_valid}, 72'd0);
    chk("rst_ready", {71'd0, if_def.prod_ready}, 72'd1);

    // Table-driven groups with acc_ready held high.
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{acc: vecs[i].acc, cnt: vecs[i].cnt, ovf: vecs[i].ovf});
      for (int j = 0; j < vecs[i].n; j++) begin
        send(vecs[i].p[j], (j == vecs[i].n - 1));
      end
      tb_prod_valid = 1'b0;
      tb_prod_last  = 1'b0;
      chk($sformatf("v%0d_valid_n1", i), {71'd0, if_def.acc_valid}, 72'd1);
      chk($sformatf("v%0d_ready_busy", i), {71'd0, if_def.prod_ready}, 72'd0);
      chk($sformatf("v%0d_w64_acc", i), {8'd0, if_w64.acc}, {8'd0, vecs[i].acc64});
      chk($sformatf("v%0d_w64_ovf", i), {71'd0, if_w64.acc_ovf}, {71'd0, vecs[i].ovf64});
      chk($sformatf("v%0d_c2_count", i), {70'd0, if_c2.acc_count}, {70'd0, vecs[i].cnt2});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_idle", i), {71'd0, if_def.prod_ready}, 72'd1);
      chk($sformatf("v%0d_valid_drop", i), {71'd0, if_def.acc_valid}, 72'd0);
      chk($sformatf("v%0d_acc_kept", i), if_def.acc, vecs[i].acc);
    end

    // Backpressure: result held while acc_ready is low, products refused.
    tb_acc_ready = 1'b0;
    sb.push_back('{acc: 72'd3, cnt: 8'd2, ovf: 1'b0});
    send(64'd1, 1'b0);
    send(64'd2, 1'b1);
    tb_prod       = 64'd99;
    tb_prod_last  = 1'b0;
    tb_prod_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", {71'd0, if_def.acc_valid}, 72'd1);
      chk("bp_acc", if_def.acc, 72'd3);
      chk("bp_count", {64'd0, if_def.acc_count}, 72'd2);
      chk("bp_ready", {71'd0, if_def.prod_ready}, 72'd0);
      @(posedge clk); #1;
    end
    tb_prod_valid = 1'b0;
    tb_acc_ready  = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after", {71'd0, if_def.prod_ready}, 72'd1);
    chk("bp_acc_after", if_def.acc, 72'd3);

    // Reset in the middle of a group discards it.
    send(64'd10, 1'b0);
    send(64'd20, 1'b0);
    tb_prod_valid = 1'b0;
    chk("mid_partial_acc", if_def.acc, 72'd30);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_acc", if_def.acc, 72'd0);
    chk("mid_rst_count", {64'd0, if_def.acc_count}, 72'd0);
    chk("mid_rst_valid", {71'd0, if_def.acc_valid}, 72'd0);
    chk("mid_rst_ready", {71'd0, if_def.prod_ready}, 72'd1);
    sb.push_back('{acc: 72'd7, cnt: 8'd1, ovf: 1'b0});
    send(64'd7, 1'b1);
    tb_prod_valid = 1'b0;
    tb_prod_last  = 1'b0;
    chk("mid_next_valid", {71'd0, if_def.acc_valid}, 72'd1);
    chk("mid_next_acc", if_def.acc, 72'd7);
    chk("mid_next_count", {64'd0, if_def.acc_count}, 72'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("sb_drained", 72'(sb.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
